// File: rtl/hard_mem_1rw_req_ctrl_pkg.sv
// Shared definitions for the 1RW hard-SRAM request controller.
//   ctrl_state_e : controller state (zero-fill sweep, then live operation)
//   BYTE_WIDTH   : width of one SRAM byte lane / macro
package hard_mem_1rw_req_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_e;

    localparam int BYTE_WIDTH = 8;

endpackage

// File: rtl/hard_mem_1rw_req_ctrl_resp_fifo.sv
// Read-response FIFO for the 1RW SRAM request controller.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   v_i, data_i      : push strobe and data (SRAM read data)
//   v_o, data_o      : head valid and head data (zero while empty)
//   yumi_i           : consumer pops the head (ignored while empty)
//   count_o          : current occupancy, used by the controller's credit logic
// A push on a full FIFO is only legal together with a pop; the controller's
// credit accounting guarantees this.
module hard_mem_resp_fifo #(
    parameter int DEPTH_P  = 2,
    parameter int WIDTH_P  = 32,
    parameter int CNT_W_P  = $clog2(DEPTH_P + 1)
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [WIDTH_P-1:0] data_i,
    output logic               v_o,
    output logic [WIDTH_P-1:0] data_o,
    input  logic               yumi_i,
    output logic [CNT_W_P-1:0] count_o
);

    localparam int PTR_W = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;

    logic [WIDTH_P-1:0] mem_r [DEPTH_P];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W_P-1:0] count_r;
    logic               push_s;
    logic               pop_s;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH_P - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Push/pop qualification.
    always_comb begin
        push_s = v_i;
        pop_s  = yumi_i & (count_r != {CNT_W_P{1'b0}});
    end

    // Entry storage, cleared on reset so no stale response survives.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < DEPTH_P; i++) begin
                mem_r[i] <= {WIDTH_P{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    // Read/write pointers and occupancy.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W_P{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W_P'(1);
                2'b01:   count_r <= count_r - CNT_W_P'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head presentation; data reads as zero while empty.
    always_comb begin
        v_o     = (count_r != {CNT_W_P{1'b0}});
        count_o = count_r;
        if (v_o) begin
            data_o = mem_r[rd_ptr_r];
        end else begin
            data_o = {WIDTH_P{1'b0}};
        end
    end

endmodule

// File: rtl/hard_mem_1rw_req_ctrl.sv
// Request-side controller for a byte-masked 1RW hard SRAM.
// Ports:
//   clk_i, reset_n_i        : clock, asynchronous active-low reset
//   v_i/w_i/addr_i/data_i/mask_i/ready_o : core request (valid/ready)
//   v_o/data_o/yumi_i       : read response (valid/yumi), in request order
//   init_done_o             : zero-fill complete, controller live
//   mem_v_n_o/mem_w_n_o     : SRAM select / write enable, active low
//   mem_addr_o/mem_data_o/mem_mask_o/mem_data_i : SRAM address, data, lane mask
// Requests are issued to the SRAM combinationally in the handshake cycle; read
// data returns one cycle later and is captured into a small response FIFO.
module hard_mem_1rw_req_ctrl
    import hard_mem_1rw_req_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH_P = 10,
    parameter int DATA_WIDTH_P = 32,
    parameter int MASK_WIDTH_P = DATA_WIDTH_P / BYTE_WIDTH,
    parameter int RESP_DEPTH_P = 2,
    parameter int INIT_ZERO_P  = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    v_i,
    input  logic                    w_i,
    input  logic [ADDR_WIDTH_P-1:0] addr_i,
    input  logic [DATA_WIDTH_P-1:0] data_i,
    input  logic [MASK_WIDTH_P-1:0] mask_i,
    output logic                    ready_o,
    output logic                    v_o,
    output logic [DATA_WIDTH_P-1:0] data_o,
    input  logic                    yumi_i,
    output logic                    init_done_o,
    output logic                    mem_v_n_o,
    output logic                    mem_w_n_o,
    output logic [ADDR_WIDTH_P-1:0] mem_addr_o,
    output logic [DATA_WIDTH_P-1:0] mem_data_o,
    output logic [MASK_WIDTH_P-1:0] mem_mask_o,
    input  logic [DATA_WIDTH_P-1:0] mem_data_i
);

    localparam int DEPTH  = 1 << ADDR_WIDTH_P;
    localparam int INIT_W = ADDR_WIDTH_P + 1;
    localparam int CNT_W  = $clog2(RESP_DEPTH_P + 1);
    localparam ctrl_state_e RESET_STATE = (INIT_ZERO_P != 0) ? ST_INIT : ST_RUN;

    ctrl_state_e       state_r;
    ctrl_state_e       state_n_s;
    logic [INIT_W-1:0] init_cnt_r;
    logic              rd_pend_r;
    logic [CNT_W-1:0]  fifo_count_s;
    logic [CNT_W:0]    occ_s;
    logic              issue_s;
    logic              fifo_yumi_s;

    // Controller state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= RESET_STATE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next state: leave the sweep once the last word has been written.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (init_cnt_r == INIT_W'(DEPTH - 1)) begin
                    state_n_s = ST_RUN;
                end else begin
                    state_n_s = ST_INIT;
                end
            end
            ST_RUN:  state_n_s = ST_RUN;
            default: state_n_s = ST_INIT;
        endcase
    end

    // Zero-fill sweep address counter.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            init_cnt_r <= {INIT_W{1'b0}};
        end else if (state_r == ST_INIT) begin
            init_cnt_r <= init_cnt_r + INIT_W'(1);
        end
    end

    // Credit check: entries held plus the read in flight, less a pop happening
    // now, must leave room for one more response. Writes are gated too so the
    // ready path never depends on w_i.
    always_comb begin
        fifo_yumi_s = yumi_i & v_o;
        occ_s       = (CNT_W + 1)'(fifo_count_s) + (CNT_W + 1)'(rd_pend_r)
                    - (CNT_W + 1)'(fifo_yumi_s);
        if (reset_n_i && (state_r == ST_RUN)) begin
            ready_o = (occ_s < (CNT_W + 1)'(RESP_DEPTH_P));
        end else begin
            ready_o = 1'b0;
        end
        issue_s     = v_i & ready_o;
        init_done_o = (state_r == ST_RUN);
    end

    // A read issued this cycle has its data on mem_data_i next cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_pend_r <= 1'b0;
        end else begin
            rd_pend_r <= issue_s & ~w_i;
        end
    end

    // SRAM port mux: idle during reset, sweep writes during INIT, core
    // requests during RUN.
    always_comb begin
        mem_v_n_o  = 1'b1;
        mem_w_n_o  = 1'b1;
        mem_addr_o = {ADDR_WIDTH_P{1'b0}};
        mem_data_o = {DATA_WIDTH_P{1'b0}};
        mem_mask_o = {MASK_WIDTH_P{1'b0}};
        if (!reset_n_i) begin
            mem_v_n_o = 1'b1;
        end else begin
            case (state_r)
                ST_INIT: begin
                    mem_v_n_o  = 1'b0;
                    mem_w_n_o  = 1'b0;
                    mem_addr_o = init_cnt_r[ADDR_WIDTH_P-1:0];
                    mem_data_o = {DATA_WIDTH_P{1'b0}};
                    mem_mask_o = {MASK_WIDTH_P{1'b1}};
                end
                ST_RUN: begin
                    mem_v_n_o  = ~issue_s;
                    mem_w_n_o  = ~w_i;
                    mem_addr_o = addr_i;
                    mem_data_o = data_i;
                    if (w_i) begin
                        mem_mask_o = mask_i;
                    end else begin
                        mem_mask_o = {MASK_WIDTH_P{1'b0}};
                    end
                end
                default: begin
                    mem_v_n_o = 1'b1;
                end
            endcase
        end
    end

    hard_mem_resp_fifo #(
        .DEPTH_P (RESP_DEPTH_P),
        .WIDTH_P (DATA_WIDTH_P),
        .CNT_W_P (CNT_W)
    ) u_resp_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (rd_pend_r),
        .data_i    (mem_data_i),
        .v_o       (v_o),
        .data_o    (data_o),
        .yumi_i    (fifo_yumi_s),
        .count_o   (fifo_count_s)
    );

endmodule
